// File: rtl/if_id_queue.sv
// In-order DEPTH-entry queue between fetch (valid/ready) and decode (stall/flush).
// Optional performance counters are built when IFID_PERF_EN is defined.
module if_id_queue #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_F,
  output logic                     ready_F,
  input  logic [ADDR_W-1:0]        PC_F,
  input  logic [INSTR_W-1:0]       imem_data,
  input  logic                     stall_D,
  input  logic                     flush_D,
  output logic                     valid_D,
  output logic [ADDR_W-1:0]        PC_D,
  output logic [INSTR_W-1:0]       instruction_D,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Fetch handshake: an entry transfers on any edge where valid_F && ready_F.
  // Fetch keeps valid_F, PC_F and imem_data stable until that happens.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign ready_F = !full;
  assign push    = valid_F && ready_F;
  assign pop     = valid_D && !stall_D && !flush_D;

  // Outputs come from registered state only; no input reaches them combinationally.
  assign valid_D       = !empty;
  assign PC_D          = empty ? '0 : pc_mem[rd_ptr];
  assign instruction_D = empty ? NOP_INSTR : instr_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_D) begin
      // Leaving wr_ptr alone and snapping rd_ptr to it empties the buffer.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush_D) begin
      pc_mem[wr_ptr]    <= PC_F;
      instr_mem[wr_ptr] <= imem_data;
    end
  end

`ifdef IFID_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (valid_D && stall_D && !flush_D)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      // A flush discards everything queued plus any entry accepted that cycle.
      if (flush_D)
        perf_drop_cnt <= perf_drop_cnt + 32'(count) + 32'(push);
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: vector table, random-stall wrap run, async reset.
// Expects the IFID_PERF_EN counter values only when that macro is defined.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_F;
  logic        ready_F;
  logic [31:0] PC_F;
  logic [31:0] imem_data;
  logic        stall_D;
  logic        flush_D;
  logic        valid_D;
  logic [31:0] PC_D;
  logic [31:0] instruction_D;
  logic [2:0]  count;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_drop_cnt;

  int checks   = 0;
  int failures = 0;

  if_id_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .valid_F(valid_F), .ready_F(ready_F),
    .PC_F(PC_F), .imem_data(imem_data), .stall_D(stall_D), .flush_D(flush_D),
    .valid_D(valid_D), .PC_D(PC_D), .instruction_D(instruction_D),
    .count(count), .perf_stall_cnt(perf_stall_cnt), .perf_drop_cnt(perf_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vf;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        st;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    logic        erdy;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return (pc == 32'h100) ? 32'h00500093 : (32'hA000_0000 | pc);
  endfunction

  function automatic vec_t mk(input logic vf, input logic [31:0] pc, input logic st,
                              input logic fl, input logic ev, input logic [31:0] epc,
                              input logic erdy, input logic [2:0] ecnt);
    vec_t v;
    v.vf = vf; v.pc = pc; v.ins = ins_of(pc); v.st = st; v.fl = fl;
    v.ev = ev; v.epc = epc; v.eins = ev ? ins_of(epc) : NOP;
    v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [31:0] eins, input logic erdy, input logic [2:0] ecnt);
    check({tag, ".valid_D"}, {31'd0, valid_D}, {31'd0, ev});
    check({tag, ".PC_D"}, PC_D, epc);
    check({tag, ".instruction_D"}, instruction_D, eins);
    check({tag, ".ready_F"}, {31'd0, ready_F}, {31'd0, erdy});
    check({tag, ".count"}, {29'd0, count}, {29'd0, ecnt});
  endtask

  task automatic drive(input logic vf, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic fl);
    valid_F = vf; PC_F = pc; imem_data = ins; stall_D = st; flush_D = fl;
  endtask

  initial begin
    int exp_stall;
    logic prev_ev;
    int n_in;
    int n_out;
    int cyc;
    logic m_push;
    logic m_pop;

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("in_reset", 1'b0, 32'd0, NOP, 1'b1, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (5) vecs.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 32'h100, 1, 1));
    vecs.push_back(mk(1, 32'h104, 0, 0, 1, 32'h104, 1, 1));
    vecs.push_back(mk(1, 32'h108, 0, 0, 1, 32'h108, 1, 1));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(1, 32'h0, 1, 0, 1, 32'h0, 1, 1));
    vecs.push_back(mk(1, 32'h4, 1, 0, 1, 32'h0, 1, 2));
    vecs.push_back(mk(1, 32'h8, 1, 0, 1, 32'h0, 1, 3));
    vecs.push_back(mk(1, 32'hC, 1, 0, 1, 32'h0, 0, 4));
    vecs.push_back(mk(1, 32'h10, 1, 0, 1, 32'h0, 0, 4));
    vecs.push_back(mk(1, 32'h10, 0, 0, 1, 32'h4, 1, 3));
    vecs.push_back(mk(1, 32'h10, 0, 0, 1, 32'h8, 1, 3));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 32'hC, 1, 2));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 32'h10, 1, 1));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(1, 32'h40, 1, 0, 1, 32'h40, 1, 1));
    vecs.push_back(mk(1, 32'h44, 1, 0, 1, 32'h40, 1, 2));
    vecs.push_back(mk(1, 32'h48, 1, 0, 1, 32'h40, 1, 3));
    vecs.push_back(mk(1, 32'h20, 0, 1, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 32'h0, 1, 0));

    exp_stall = 0;
    prev_ev = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (prev_ev && vecs[i].st && !vecs[i].fl) exp_stall++;
      prev_ev = vecs[i].ev;
      drive(vecs[i].vf, vecs[i].pc, vecs[i].ins, vecs[i].st, vecs[i].fl);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eins,
                    vecs[i].erdy, vecs[i].ecnt);
    end

`ifdef IFID_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, 32'(exp_stall));
    check("perf_drop_cnt", perf_drop_cnt, 32'd4);
`else
    check("perf_stall_cnt", perf_stall_cnt, 32'd0);
    check("perf_drop_cnt", perf_drop_cnt, 32'd0);
`endif

    // Wrap-around run: 3*DEPTH+1 entries under seeded random stall.
    void'($urandom(32'd7));
    exp_q.delete();
    n_in = 0;
    n_out = 0;
    cyc = 0;
    while (n_out < 3*DEPTH+1 && cyc < 400) begin
      stall_D = 1'($urandom_range(0, 1));
      flush_D = 1'b0;
      valid_F = (n_in < 3*DEPTH+1);
      PC_F = 32'h200 + 32'(4*n_in);
      imem_data = ins_of(PC_F);
      m_push = valid_F && (exp_q.size() != DEPTH);
      m_pop = (exp_q.size() != 0) && !stall_D;
      @(posedge clk);
      #1;
      if (m_pop) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (m_push) begin
        exp_q.push_back(PC_F);
        n_in++;
      end
      cyc++;
      check("wrap.count", {29'd0, count}, 32'(exp_q.size()));
      check("wrap.count_le_depth", {31'd0, (count <= 3'(DEPTH))}, 32'd1);
      if (exp_q.size() != 0) begin
        check("wrap.PC_D", PC_D, exp_q[0]);
        check("wrap.instruction_D", instruction_D, ins_of(exp_q[0]));
      end else begin
        check("wrap.empty_valid_D", {31'd0, valid_D}, 32'd0);
      end
    end
    check("wrap.all_entries_out", 32'(n_out), 32'(3*DEPTH+1));

    // Asynchronous reset with two entries queued.
    drive(1'b1, 32'h280, ins_of(32'h280), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 32'h284, ins_of(32'h284), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("pre_reset", 1'b1, 32'h280, ins_of(32'h280), 1'b1, 3'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 32'd0, NOP, 1'b1, 3'd0);
    check("async_reset.perf_stall_cnt", perf_stall_cnt, 32'd0);
    check("async_reset.perf_drop_cnt", perf_drop_cnt, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'h300, ins_of(32'h300), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("post_reset_push", 1'b1, 32'h300, ins_of(32'h300), 1'b1, 3'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("post_reset_drain", 1'b0, 32'd0, NOP, 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
